// File: rtl/core_prefetch_unit.sv
// core_prefetch_unit: pipelined req/grant instruction fetch feeding an in-order prefetch FIFO,
// with redirect squash of buffered and in-flight fetches. CORE_FETCH_PERF_EN adds perf counters.
module core_prefetch_unit #(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            inst_req_o,
  input  logic            inst_grnt_i,
  output logic [XLEN-1:0] inst_addr_o,
  input  logic [XLEN-1:0] inst_data_i,
  input  logic            inst_valid_i,
  input  logic            halt_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i
`ifdef CORE_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt_o,
  output logic [31:0]     perf_bubble_cnt_o
`endif
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = FW + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [FW-1:0]   r_count;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [XLEN-1:0] r_fifo_instr [DEPTH];
  logic [XLEN-1:0] r_fifo_pc    [DEPTH];

  logic [SW-1:0]   w_credit_sum;
  logic            w_req;
  logic            w_fire;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_nonempty;
  logic [CW-1:0]   w_out_next;
  logic [XLEN-1:0] w_redirect_pc;

  // Entries already buffered plus live in-flight fetches must fit in the FIFO;
  // fetches that will be dropped do not consume a slot.
  assign w_credit_sum  = SW'(r_count) + SW'(r_outstanding) - SW'(r_drop_cnt);
  assign w_req         = !rst_i && !halt_i && !redirect_i
                         && (r_outstanding < CW'(MAX_OUTSTANDING))
                         && (w_credit_sum < SW'(DEPTH));
  assign w_fire        = w_req && inst_grnt_i;
  assign w_nonempty    = (r_count != '0);
  assign w_pop         = w_nonempty && instr_ready_i;
  assign w_drop        = inst_valid_i && (r_drop_cnt != '0);
  assign w_push        = inst_valid_i && (r_drop_cnt == '0) && !redirect_i;
  assign w_out_next    = r_outstanding + CW'(w_fire) - CW'(inst_valid_i);
  assign w_redirect_pc = redirect_pc_i & ~XLEN'(3);

  assign inst_req_o    = w_req;
  assign inst_addr_o   = r_fetch_pc;
  assign instr_valid_o = w_nonempty;
  assign instr_o       = w_nonempty ? r_fifo_instr[r_rptr] : '0;
  assign pc_o          = w_nonempty ? r_fifo_pc[r_rptr]    : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect_i) begin
        // Everything still in flight after this cycle belongs to the old stream.
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_drop_cnt <= w_out_next;
        r_count    <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
      end else begin
        if (w_fire) begin
          r_fetch_pc <= r_fetch_pc + XLEN'(4);
        end
        if (w_drop) begin
          r_drop_cnt <= r_drop_cnt - CW'(1);
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + XLEN'(4);
          r_wptr    <= r_wptr + AW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + AW'(1);
        end
        r_count <= r_count + FW'(w_push) - FW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_instr[r_wptr] <= inst_data_i;
      r_fifo_pc[r_wptr]    <= r_resp_pc;
    end
  end

`ifdef CORE_FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_bubble;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_fetch  <= '0;
      r_perf_bubble <= '0;
    end else begin
      if (w_pop && (r_perf_fetch != '1)) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (instr_ready_i && !w_nonempty && (r_perf_bubble != '1)) begin
        r_perf_bubble <= r_perf_bubble + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt_o  = r_perf_fetch;
  assign perf_bubble_cnt_o = r_perf_bubble;
`endif

  always @(posedge clk_i) begin
    if (!rst_i) begin
      a_resp_without_req: assert (!(inst_valid_i && (r_outstanding == '0)));
      a_push_when_full:   assert (!(w_push && !w_pop && (r_count == FW'(DEPTH))));
    end
  end

endmodule
